// File: rtl/vga_plot_arbiter.sv
// Round-robin sharing of one registered pixel-plot port among N_REQ drawing engines,
// plus a full-frame clear sequencer emitting one pixel per clock in row-major order.
module vga_plot_arbiter #(
  parameter int N_REQ = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic                 CLOCK_50,
  input  logic                 Resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   x_in,
  input  logic [7*N_REQ-1:0]   y_in,
  input  logic [3*N_REQ-1:0]   color_in,
  output logic [N_REQ-1:0]     gnt,
  input  logic                 clear_req,
  input  logic [2:0]           clear_color,
  output logic                 clear_busy,
  output logic [7:0]           VGA_X,
  output logic [6:0]           VGA_Y,
  output logic [2:0]           VGA_COLOR,
  output logic                 plot
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);
  localparam logic [8:0] X_LIM  = 9'(X_MAX);
  localparam logic [7:0] Y_LIM  = 8'(Y_MAX);

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic [7:0]       vx_q, vx_d;
  logic [6:0]       vy_q, vy_d;
  logic [2:0]       vc_q, vc_d;
  logic [7:0]       cx_q, cx_d;
  logic [6:0]       cy_q, cy_d;
  logic [2:0]       ccol_q, ccol_d;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    cand;
  logic [7:0]       win_x;
  logic [6:0]       win_y;
  logic [2:0]       win_c;
  logic             win_oob;

  // A requester granted last cycle is masked so it can update its data or drop req.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % N_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_x   = x_in[int'(win)*8 +: 8];
    win_y   = y_in[int'(win)*7 +: 7];
    win_c   = color_in[int'(win)*3 +: 3];
    win_oob = ({1'b0, win_x} >= X_LIM) || ({1'b0, win_y} >= Y_LIM);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ccol_d  = ccol_q;

    if (state_q == ST_CLEAR) begin
      plot_d = 1'b1;
      busy_d = 1'b1;
      vx_d   = cx_q;
      vy_d   = cy_q;
      vc_d   = ccol_q;
      // Leaving on the last pixel lets the next edge arbitrate with no idle gap.
      if (cx_q == X_LAST) begin
        cx_d = '0;
        if (cy_q == Y_LAST) begin
          cy_d    = '0;
          state_d = ST_ARB;
        end else begin
          cy_d = cy_q + 7'd1;
        end
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end else if (clear_req) begin
      ccol_d  = clear_color;
      state_d = ST_CLEAR;
      plot_d  = 1'b1;
      busy_d  = 1'b1;
      vx_d    = '0;
      vy_d    = '0;
      vc_d    = clear_color;
      cx_d    = 8'd1;
      cy_d    = '0;
    end else if (found) begin
      gnt_d[win] = 1'b1;
      plot_d     = !win_oob;
      vx_d       = win_x;
      vy_d       = win_y;
      vc_d       = win_c;
      ptr_d      = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ccol_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ccol_q  <= ccol_d;
    end
  end

  assign gnt        = gnt_q;
  assign plot       = plot_q;
  assign clear_busy = busy_q;
  assign VGA_X      = vx_q;
  assign VGA_Y      = vy_q;
  assign VGA_COLOR  = vc_q;

endmodule
